video_resampler: RTL
====================

Name: video_resampler

Overview:
- Parametrised pixel/line decimator that replaces the fixed divide-by-9 skip (DIV megafunction plus remainder compare) between the ITU-R 656 decoder and the frame buffer.
- Drops input pixels and lines evenly, using Bresenham-style accumulators, to map IN_H x IN_V active video onto OUT_H x OUT_V.
- Emits marker-tagged pixels with output coordinates and flags malformed lines and frames.
- Sits in the TD_CLK27 domain, downstream of colour conversion and upstream of the SDRAM write FIFO.

Parameters:
- DATA_W, 16, pixel word width (packed RGB565 by default).
- IN_H, 720, input active pixels per line.
- OUT_H, 640, output pixels per line; must satisfy 1 <= OUT_H <= IN_H.
- IN_V, 480, input active lines per frame.
- OUT_V, 480, output lines per frame; must satisfy 1 <= OUT_V <= IN_V.
- X_W, 11, width of out_x.
- Y_W, 11, width of out_y.

Ports:
- clk  in  1  pixel clock (TD_CLK27).
- areset  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  input pixel.
- in_valid  in  1  in_data and the markers are valid this cycle.
- in_sol  in  1  start of line; qualified by in_valid.
- in_sof  in  1  start of frame; qualified by in_valid; implies in_sol.
- bypass  in  1  pass all pixels unscaled; sampled only at sof.
- out_data  out  DATA_W  kept pixel.
- out_valid  out  1  out_data valid.
- out_sol  out  1  first kept pixel of an output line.
- out_sof  out  1  first kept pixel of an output frame.
- out_x  out  X_W  output column of out_data.
- out_y  out  Y_W  output row of out_data.
- err_long  out  1  one-cycle pulse: a kept pixel exceeded OUT_H and was discarded.
- err_short  out  1  one-cycle pulse: a line ended with fewer than OUT_H kept pixels.
- err_frame  out  1  one-cycle pulse: a line exceeded OUT_V and was discarded.

Behaviour:
- Reset: clock and reset are fixed as one clock, clk; areset is asynchronous and active-high.
  - All outputs reset to 0.
  - Both accumulators reset to 0.
  - FSM enters WAIT_SOF.
  - Reset is honoured mid-line: output stops immediately, with no flush.
- FSM states: WAIT_SOF, ACTIVE_LINE, SKIP_LINE.
  - WAIT_SOF: ignore everything until in_valid & in_sof.
  - On any sol, evaluate the vertical keep decision and go to ACTIVE_LINE (line kept) or SKIP_LINE (line dropped).
  - in_sof in any state restarts the frame: vacc=0, row=0, latch bypass.
- Horizontal decimation, with D_H = IN_H - OUT_H:
  - hacc clears at every sol.
  - For each valid pixel in ACTIVE_LINE: s = hacc + D_H. If s >= IN_H, drop the pixel and set hacc = s - IN_H; otherwise keep it and set hacc = s.
  - The sol pixel itself is evaluated the same way.
  - Accumulator width: clog2(IN_H)+1, with no overflow.
- Vertical decimation uses the same rule, with D_V = IN_V - OUT_V, applied once per input line at its sol.
- bypass latched 1: every pixel and every line is kept; counters and error checks still run.
- Coordinates:
  - out_x = number of kept pixels before this one in the line.
  - out_y = number of kept lines before this one in the frame.
  - A kept pixel with col == OUT_H is discarded and pulses err_long.
  - A kept line with row == OUT_V is discarded (treated as SKIP_LINE) and pulses err_frame.
- err_short: at a sol or sof, if the previous line was ACTIVE_LINE and its kept count != OUT_H, pulse err_short in the cycle that the new pixel's result is registered.
- Latency: exactly 1 clk from an input pixel to its output; all outputs are registered.
- out_sol is asserted on the kept pixel with out_x = 0; out_sof is asserted additionally when out_y = 0.
- in_valid=0 cycles: out_valid=0, and all state holds.
- Markers on a cycle with in_valid=0 are ignored.

Decomposition:
- Shared package video_pkg:
  - NTSC_RES_H=720, VGA_RES_H_ACT=640, VGA_RES_V_ACT=480.
  - FSM state enum.
  - Function clog2.
- Sub-module ratio_accumulator, parameters (TOTAL, DROP).
  - Inputs: clear, step.
  - Output: keep (combinational from the current value), updated on step.
  - Instantiated twice: horizontal and vertical.

Test Plan:
- Defaults, one 720-pixel line after sof -> 640 outputs; input indices 8, 17, ..., 719 dropped; out_x runs 0..639; no errors.
- OUT_V=240, 480 lines of 720 -> input lines 0, 2, 4, ... kept; out_y runs 0..239; odd lines produce no out_valid.
- bypass=1 at sof, 640-pixel lines -> every pixel passes; no err_short; a 720-pixel line pulses err_long 80 times.
- A line cut to 700 pixels followed by sol -> err_short pulse once; next line out_x restarts at 0.
- areset asserted at pixel 300 of a line, released, then pixels without sof -> no out_valid until in_sof; first output has out_sof=1, out_x=0, out_y=0.
- in_valid gaps (1 of 3 cycles high) -> identical kept sequence to the gap-free run; every output appears 1 cycle after its input.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants, FSM encoding and helpers for the video resampler slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package video_pkg;

    localparam int NTSC_RES_H    = 720;
    localparam int VGA_RES_H_ACT = 640;
    localparam int VGA_RES_V_ACT = 480;

    typedef enum logic [1:0] {
        WAIT_SOF,
        ACTIVE_LINE,
        SKIP_LINE
    } state_t;

    // Ceiling log2 for sizing counters from elaboration-time parameters.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/video_resampler_ratio_accumulator.sv
// Bresenham keep/drop decision: keeps TOTAL-DROP of every TOTAL steps, spread evenly.
// Latency: keep is combinational from the current accumulator (with clear applied); state updates on step.
// Backpressure: none; the caller only pulses step for items it actually consumes.
module ratio_accumulator
    import video_pkg::*;
#(
    parameter int TOTAL = 720,
    parameter int DROP  = 80
) (
    input  logic clk,
    input  logic areset,
    input  logic clear,
    input  logic step,
    output logic keep
);

    // One extra bit so acc + DROP never wraps (acc < TOTAL, DROP <= TOTAL).
    localparam int AW = clog2(TOTAL) + 1;
    localparam logic [AW-1:0] TOTAL_A = AW'(TOTAL);
    localparam logic [AW-1:0] DROP_A  = AW'(DROP);

    logic [AW-1:0] acc;
    logic [AW-1:0] base;
    logic [AW-1:0] sum;

    // A clear coinciding with a step means the item is judged from a fresh accumulator.
    always_comb begin
        base = clear ? '0 : acc;
        sum  = base + DROP_A;
        keep = (sum < TOTAL_A);
    end

    // Advance on step (subtracting TOTAL on a drop), otherwise honour a bare clear.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            acc <= '0;
        end else if (step) begin
            acc <= keep ? sum : (sum - TOTAL_A);
        end else if (clear) begin
            acc <= '0;
        end
    end

endmodule

// File: rtl/video_resampler.sv
// Decimates IN_H x IN_V active video to OUT_H x OUT_V, tagging kept pixels with sol/sof and x/y.
// Latency: exactly one clk from an input pixel to its registered output.
// Backpressure: none; in_valid low simply stalls all state and output is never stalled.
module video_resampler
    import video_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IN_H   = NTSC_RES_H,
    parameter int OUT_H  = VGA_RES_H_ACT,
    parameter int IN_V   = VGA_RES_V_ACT,
    parameter int OUT_V  = VGA_RES_V_ACT,
    parameter int X_W    = 11,
    parameter int Y_W    = 11
) (
    input  logic              clk,
    input  logic              areset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sol,
    input  logic              in_sof,
    input  logic              bypass,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_sol,
    output logic              out_sof,
    output logic [X_W-1:0]    out_x,
    output logic [Y_W-1:0]    out_y,
    output logic              err_long,
    output logic              err_short,
    output logic              err_frame
);

    localparam logic [X_W-1:0] OUT_H_X = X_W'(OUT_H);
    localparam logic [Y_W-1:0] OUT_V_Y = Y_W'(OUT_V);

    state_t         state, state_nx;
    logic           bypass_q, byp_eff;
    logic [X_W-1:0] col, col_cur, col_nx;
    logic [Y_W-1:0] row, row_cur, row_nx;
    logic [Y_W-1:0] line_y, line_y_nx;
    logic           accept, sof_acc, sol_acc, line_keep;
    logic           h_step, h_keep, v_keep;
    logic           px_keep, px_out, long_err, short_err, frame_err;

    ratio_accumulator #(.TOTAL(IN_H), .DROP(IN_H - OUT_H)) u_hacc (
        .clk    (clk),
        .areset (areset),
        .clear  (sol_acc),
        .step   (h_step),
        .keep   (h_keep)
    );

    ratio_accumulator #(.TOTAL(IN_V), .DROP(IN_V - OUT_V)) u_vacc (
        .clk    (clk),
        .areset (areset),
        .clear  (sof_acc),
        .step   (sol_acc),
        .keep   (v_keep)
    );

    // Line/pixel decisions for the current input beat; everything holds when nothing is accepted.
    always_comb begin
        accept    = in_valid && ((state != WAIT_SOF) || in_sof);
        sof_acc   = accept && in_sof;
        sol_acc   = accept && (in_sol || in_sof);
        byp_eff   = sof_acc ? bypass : bypass_q;
        row_cur   = sof_acc ? '0 : row;
        line_keep = v_keep || byp_eff;
        state_nx  = state;
        row_nx    = row_cur;
        line_y_nx = line_y;
        frame_err = 1'b0;
        if (sol_acc) begin
            if (line_keep && (row_cur < OUT_V_Y)) begin
                state_nx  = ACTIVE_LINE;
                line_y_nx = row_cur;
                row_nx    = row_cur + 1'b1;
            end else begin
                // A kept line past OUT_V is discarded like a dropped one, but flagged.
                state_nx  = SKIP_LINE;
                frame_err = line_keep;
            end
        end
        short_err = sol_acc && (state == ACTIVE_LINE) && (col != OUT_H_X);
        col_cur   = sol_acc ? '0 : col;
        h_step    = accept && (state_nx == ACTIVE_LINE);
        px_keep   = h_step && (h_keep || byp_eff);
        px_out    = px_keep && (col_cur < OUT_H_X);
        long_err  = px_keep && !px_out;
        // col saturates at OUT_H so an over-long line does not also count as short.
        col_nx    = px_out ? (col_cur + 1'b1) : col_cur;
    end

    // Register FSM, counters and every output; reset drops output immediately.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state     <= WAIT_SOF;
            bypass_q  <= 1'b0;
            col       <= '0;
            row       <= '0;
            line_y    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sol   <= 1'b0;
            out_sof   <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            err_long  <= 1'b0;
            err_short <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            state     <= state_nx;
            bypass_q  <= byp_eff;
            col       <= col_nx;
            row       <= row_nx;
            line_y    <= line_y_nx;
            out_valid <= px_out;
            out_sol   <= px_out && (col_cur == '0);
            out_sof   <= px_out && (col_cur == '0) && (line_y_nx == '0);
            err_long  <= long_err;
            err_short <= short_err;
            err_frame <= frame_err;
            if (px_out) begin
                out_data <= in_data;
                out_x    <= col_cur;
                out_y    <= line_y_nx;
            end
        end
    end

endmodule
